// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: registered hex nibble to seven-segment drive with blanking and selectable polarity.
module hex_seg_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] in,
  output logic [6:0] out
);
  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7f : 7'h00;
  logic [6:0] glyph;
  logic [6:0] out_d;
  // power-up value matches reset so the display is dark before the first reset
  logic [6:0] out_q = BLANK;
  always_comb begin
    glyph = 7'h00;
    case (in)
      4'h0: glyph = 7'h3f;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5b;
      4'h3: glyph = 7'h4f;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6d;
      4'h6: glyph = 7'h7d;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7f;
      4'h9: glyph = 7'h6f;
      4'ha: glyph = 7'h77;
      4'hb: glyph = 7'h7c;
      4'hc: glyph = 7'h39;
      4'hd: glyph = 7'h5e;
      4'he: glyph = 7'h79;
      4'hf: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
  end
  assign out_d = ACTIVE_LOW ? ~(en ? glyph : 7'h00) : (en ? glyph : 7'h00);
  always_ff @(posedge clk) begin
    out_q <= rst ? BLANK : out_d;
  end
  assign out = out_q;
endmodule

// File: tb/tb_hex_seg_decoder.sv
// tb_hex_seg_decoder: directed checks of both polarities against hand-computed segment tables.
module tb_hex_seg_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [3:0] in = 4'h0;
  logic [6:0] out_lo;
  logic [6:0] out_hi;
  int checks = 0;
  int errors = 0;
  logic [6:0] low_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
  logic [6:0] high_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  hex_seg_decoder #(.ACTIVE_LOW(1'b1)) u_lo (.clk(clk), .rst(rst), .en(en), .in(in), .out(out_lo));
  hex_seg_decoder #(.ACTIVE_LOW(1'b0)) u_hi (.clk(clk), .rst(rst), .en(en), .in(in), .out(out_hi));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic [3:0] n);
    @(negedge clk);
    rst = r;
    en = e;
    in = n;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("powerup_lo", out_lo, 7'h7f);
    chk("powerup_hi", out_hi, 7'h00);
    step(1'b1, 1'b1, 4'h8);
    chk("rst1_lo", out_lo, 7'h7f);
    chk("rst1_hi", out_hi, 7'h00);
    step(1'b1, 1'b1, 4'h8);
    chk("rst2_lo", out_lo, 7'h7f);
    step(1'b0, 1'b1, 4'h8);
    chk("rel_lo", out_lo, 7'h00);
    chk("rel_hi", out_hi, 7'h7f);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'(i));
      chk($sformatf("sweep_lo_%h", i), out_lo, low_tab[i]);
      chk($sformatf("sweep_hi_%h", i), out_hi, high_tab[i]);
    end
    step(1'b0, 1'b1, 4'h5);
    chk("blank_pre", out_lo, 7'h12);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'(i));
      chk($sformatf("blank_lo_%h", i), out_lo, 7'h7f);
      chk($sformatf("blank_hi_%h", i), out_hi, 7'h00);
    end
    step(1'b0, 1'b1, 4'ha);
    chk("unblank_lo", out_lo, 7'h08);
    chk("unblank_hi", out_hi, 7'h77);
    step(1'b0, 1'b1, 4'h1);
    chk("mid_1", out_lo, 7'h79);
    step(1'b1, 1'b1, 4'h2);
    chk("mid_rst", out_lo, 7'h7f);
    step(1'b0, 1'b1, 4'h3);
    chk("mid_3", out_lo, 7'h30);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1'b0;
      en = 1'b1;
      in = 4'(i % 2);
      #1;
      chk($sformatf("hold_%0d", i), out_lo, (i == 0) ? 7'h30 : low_tab[(i - 1) % 2]);
      @(posedge clk);
      #1;
      chk($sformatf("lat_%0d", i), out_lo, low_tab[i % 2]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
